// File: rtl/audio_mix_out.sv
// audio_mix_out: output mixer between the tone sources and Audio_Controller.
//
// Once per audio frame it pops one ADC sample pair, latches the mic samples and
// both tone samples, attenuates each tone by an arithmetic right shift, sums
// everything with saturation and pushes one frame to the DAC FIFO. A clip LED
// stays lit for CLIP_HOLD cycles after the most recent clipped frame.
//
// Optional feature macro: MIX_MIC_PASSTHRU_EN
//   defined   : the latched mic samples are mixed with the tones.
//   undefined : mic contribution is zero (ADC FIFO is still drained each frame).
//
// Parameters:
//   SAMPLE_W   signed sample width on all sample ports
//   CLIP_HOLD  cycles clip_led stays high after the last clipped frame
//
// Ports:
//   CLOCK_50            in   system clock
//   resetn              in   asynchronous active-low reset
//   audio_in_available  in   ADC frame ready
//   audio_out_allowed   in   DAC FIFO has space
//   left_in, right_in   in   mic samples (signed)
//   tone_a, tone_b      in   tone samples (signed)
//   vol_a, vol_b        in   per-tone right-shift attenuation 0..7
//   read_audio_in       out  one-cycle ADC pop
//   write_audio_out     out  one-cycle DAC push
//   left_out, right_out out  saturated mixed samples
//   clip_led            out  high while a clip occurred within the last CLIP_HOLD cycles
`timescale 1ns / 1ps

module audio_mix_out #(
  parameter int unsigned SAMPLE_W  = 32,
  parameter int unsigned CLIP_HOLD = 25_000_000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                audio_in_available,
  input  logic                audio_out_allowed,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic [SAMPLE_W-1:0] tone_a,
  input  logic [SAMPLE_W-1:0] tone_b,
  input  logic [2:0]          vol_a,
  input  logic [2:0]          vol_b,
  output logic                read_audio_in,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                clip_led
);

  // Two guard bits: the sum of three full-scale signed samples always fits.
  localparam int unsigned SumW = SAMPLE_W + 2;
  localparam int unsigned CntW = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD + 1) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StSum, StSat, StWaitOut} state_e;

  state_e state_q, state_d;

  logic signed [SAMPLE_W-1:0] tone_a_q, tone_b_q;
  logic [2:0]                 vol_a_q, vol_b_q;
  logic [SAMPLE_W-1:0]        mic_l, mic_r;
  logic [SumW-1:0]            sum_l_q, sum_r_q;
  logic [SumW-1:0]            sum_l_d, sum_r_d;
  logic [SAMPLE_W-1:0]        left_q, right_q;
  logic [SAMPLE_W-1:0]        sat_l, sat_r;
  logic                       clip_l, clip_r;
  logic [CntW-1:0]            hold_q;
  logic signed [SAMPLE_W-1:0] tone_a_att, tone_b_att;

  function automatic logic [SumW-1:0] sext(input logic [SAMPLE_W-1:0] v);
    return {{2{v[SAMPLE_W-1]}}, v};
  endfunction

  // No overflow iff the top three bits of the wide sum agree.
  function automatic logic [SAMPLE_W:0] saturate(input logic [SumW-1:0] s);
    logic [2:0] top;
    top = s[SumW-1 -: 3];
    if (top == 3'b000 || top == 3'b111) begin
      return {1'b0, s[SAMPLE_W-1:0]};
    end else if (!s[SumW-1]) begin
      return {1'b1, 1'b0, {(SAMPLE_W - 1){1'b1}}};
    end else begin
      return {1'b1, 1'b1, {(SAMPLE_W - 1){1'b0}}};
    end
  endfunction

`ifdef MIX_MIC_PASSTHRU_EN
  logic [SAMPLE_W-1:0] mic_l_q, mic_r_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mic_l_q <= '0;
      mic_r_q <= '0;
    end else if (state_q == StRead) begin
      mic_l_q <= left_in;
      mic_r_q <= right_in;
    end
  end

  assign mic_l = mic_l_q;
  assign mic_r = mic_r_q;
`else
  // Mic samples are popped from the ADC but deliberately not mixed.
  logic unused_mic;
  assign unused_mic = ^{left_in, right_in};
  assign mic_l      = '0;
  assign mic_r      = '0;
`endif

  // ---------------------------------------------------------------------------
  // Frame sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    read_audio_in   = 1'b0;
    write_audio_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (audio_in_available) state_d = StRead;
      end
      StRead: begin
        read_audio_in = 1'b1;
        state_d       = StSum;
      end
      StSum: state_d = StSat;
      StSat: state_d = StWaitOut;
      StWaitOut: begin
        // Write at most once; the state leaves WAIT_OUT on the write cycle.
        if (audio_out_allowed) begin
          write_audio_out = 1'b1;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign tone_a_att = tone_a_q >>> vol_a_q;
  assign tone_b_att = tone_b_q >>> vol_b_q;

  always_comb begin
    sum_l_d = sext(mic_l) + sext(tone_a_att) + sext(tone_b_att);
    sum_r_d = sext(mic_r) + sext(tone_a_att) + sext(tone_b_att);
  end

  always_comb begin
    logic [SAMPLE_W:0] res_l, res_r;
    res_l  = saturate(sum_l_q);
    res_r  = saturate(sum_r_q);
    clip_l = res_l[SAMPLE_W];
    clip_r = res_r[SAMPLE_W];
    sat_l  = res_l[SAMPLE_W-1:0];
    sat_r  = res_r[SAMPLE_W-1:0];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tone_a_q <= '0;
      tone_b_q <= '0;
      vol_a_q  <= '0;
      vol_b_q  <= '0;
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      if (state_q == StRead) begin
        tone_a_q <= tone_a;
        tone_b_q <= tone_b;
        vol_a_q  <= vol_a;
        vol_b_q  <= vol_b;
      end
      if (state_q == StSum) begin
        sum_l_q <= sum_l_d;
        sum_r_q <= sum_r_d;
      end
      if (state_q == StSat) begin
        left_q  <= sat_l;
        right_q <= sat_r;
      end
    end
  end

  assign left_out  = left_q;
  assign right_out = right_q;

  // ---------------------------------------------------------------------------
  // Clip indicator: reload on any clipped frame, otherwise count down to zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
    end else if (state_q == StSat && (clip_l || clip_r)) begin
      hold_q <= CntW'(CLIP_HOLD);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - CntW'(1);
    end
  end

  assign clip_led = (hold_q != '0);

endmodule

// File: tb/tb_audio_mix_out.sv
`timescale 1ns / 1ps

module tb_audio_mix_out;

  localparam int unsigned SW   = 32;
  localparam int unsigned HOLD = 40;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic          audio_in_available = 1'b0;
  logic          audio_out_allowed = 1'b1;
  logic [SW-1:0] left_in = '0, right_in = '0, tone_a = '0, tone_b = '0;
  logic [2:0]    vol_a = '0, vol_b = '0;
  logic          read_audio_in, write_audio_out, clip_led;
  logic [SW-1:0] left_out, right_out;

  audio_mix_out #(
    .SAMPLE_W (SW),
    .CLIP_HOLD(HOLD)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .audio_in_available(audio_in_available),
    .audio_out_allowed (audio_out_allowed),
    .left_in           (left_in),
    .right_in          (right_in),
    .tone_a            (tone_a),
    .tone_b            (tone_b),
    .vol_a             (vol_a),
    .vol_b             (vol_b),
    .read_audio_in     (read_audio_in),
    .write_audio_out   (write_audio_out),
    .left_out          (left_out),
    .right_out         (right_out),
    .clip_led          (clip_led)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    bit            clip;
    int            exp_led;  // -1: don't care unless the frame clipped
    bit            chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  int   cyc = 0;
  int   read_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference mix: 64-bit integer arithmetic, then clamp to the signed 32-bit range.
  function automatic logic [SW-1:0] mix(input logic [SW-1:0] mic, input logic [SW-1:0] ta,
                                        input logic [SW-1:0] tb, input logic [2:0] va,
                                        input logic [2:0] vb, output bit clip);
    longint a, b, s, lim;
    lim = 64'sd2147483648;
    a   = longint'($signed(ta)) >>> va;
    b   = longint'($signed(tb)) >>> vb;
    s   = a + b;
`ifdef MIX_MIC_PASSTHRU_EN
    s = s + longint'($signed(mic));
`else
    if (mic == '1) s = s + 0;  // mic ignored in this build
`endif
    clip = 1'b0;
    if (s > lim - 1) begin
      clip = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (s < -lim) begin
      clip = 1'b1;
      return 32'h8000_0000;
    end
    return s[SW-1:0];
  endfunction

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Output monitor: every DAC push pops one scoreboard entry.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resetn && read_audio_in) read_cyc <= cyc;
    if (resetn && write_audio_out) begin
      n_writes <= n_writes + 1;
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("left_out", left_out, e.l);
        check_eq("right_out", right_out, e.r);
        if (e.clip) check_eq("clip_led_on_clip", clip_led, 1);
        else if (e.exp_led >= 0) check_eq("clip_led", clip_led, 64'(e.exp_led[0]));
        if (e.chk_lat) check_eq("latency", 64'(cyc - read_cyc), 3);
      end
    end
  end

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input logic [SW-1:0] ta, input logic [SW-1:0] tb,
                            input logic [2:0] va, input logic [2:0] vb,
                            input int exp_led, input bit chk_lat, input bit push);
    exp_t e;
    bit   cl, cr, got;
    e.l       = mix(l, ta, tb, va, vb, cl);
    e.r       = mix(r, ta, tb, va, vb, cr);
    e.clip    = cl | cr;
    e.exp_led = exp_led;
    e.chk_lat = chk_lat;
    if (push) sb_q.push_back(e);
    @(negedge CLOCK_50);
    left_in = l; right_in = r; tone_a = ta; tone_b = tb; vol_a = va; vol_b = vb;
    audio_in_available = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) got = 1'b1;
    end
    check_eq("read_pulse_seen", 64'(got), 1);
    audio_in_available = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check_eq("read_one_cycle", 64'(read_audio_in), 0);
    // Inputs outside READ must be ignored.
    left_in = $urandom; right_in = $urandom; tone_a = $urandom; tone_b = $urandom;
    vol_a = 3'($urandom_range(7)); vol_b = 3'($urandom_range(7));
  endtask

  task automatic wait_write();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) got = 1'b1;
    end
    check_eq("write_seen", 64'(got), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] w;
    bit            dummy;
    int            wc, hi;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_left", left_out, 0);
    check_eq("rst_right", right_out, 0);
    check_eq("rst_read", 64'(read_audio_in), 0);
    check_eq("rst_write", 64'(write_audio_out), 0);
    check_eq("rst_clip", 64'(clip_led), 0);
    resetn = 1'b1;

    // Basic mixes, attenuation, mic contribution
    send_frame(100, 100, 50_000_000, 0, 0, 0, 0, 1, 1);
    wait_write();
    send_frame(0, 0, -50_000_000, 7, 2, 1, 0, 1, 1);
    wait_write();
    send_frame(500, -3, 0, 0, 0, 0, 0, 1, 1);
    wait_write();
    send_frame(-7, 9, 32'h0000_1000, 32'hFFFF_F000, 3, 7, 0, 1, 1);
    wait_write();

    // Saturation cases, back-to-back clips reload the hold counter
    send_frame(32'h7FFF_0000, 32'h7FFF_0000, 50_000_000, 0, 0, 0, -1, 1, 1);
    wait_write();
    send_frame(0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, -1, 1, 1);
    wait_write();
    send_frame(32'h8000_0010, 32'h8000_0010, -50_000_000, -1, 0, 0, -1, 1, 1);
    wait_write();
    send_frame(0, 5, 32'h8000_0000, 32'h8000_0000, 0, 0, -1, 1, 1);
    wait_write();
    hi = 1;
    for (int i = 0; i < 3 * HOLD; i++) begin
      @(negedge CLOCK_50);
      if (clip_led) hi++;
      else break;
    end
    check_eq("clip_hold_len", 64'(hi), HOLD);
    @(negedge CLOCK_50);
    check_eq("clip_led_off", 64'(clip_led), 0);

    // DAC back-pressure: hold in WAIT_OUT, then exactly one write
    audio_out_allowed = 1'b0;
    w = mix(1234, 1000, -2000, 1, 0, dummy);
    send_frame(1234, 1234, 1000, -2000, 1, 0, 0, 0, 1);
    repeat (2) @(negedge CLOCK_50);
    wc = n_writes;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      check_eq("stall_left", left_out, w);
      check_eq("stall_no_write", 64'(write_audio_out), 0);
    end
    check_eq("stall_write_count", 64'(n_writes), 64'(wc));
    @(posedge CLOCK_50);
    #1;
    audio_out_allowed = 1'b1;
    wait_write();
    repeat (5) @(negedge CLOCK_50);
    check_eq("one_write_after_stall", 64'(n_writes), 64'(wc + 1));

    // Reset mid-frame (during SUM) while outputs and clip LED are active
    send_frame(0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, -1, 1, 1);
    wait_write();
    send_frame(11, 22, 33, 44, 0, 0, -1, 0, 0);
    wc = n_writes;
    resetn = 1'b0;
    #1;
    check_eq("midrst_left", left_out, 0);
    check_eq("midrst_right", right_out, 0);
    check_eq("midrst_clip", 64'(clip_led), 0);
    check_eq("midrst_read", 64'(read_audio_in), 0);
    check_eq("midrst_write", 64'(write_audio_out), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check_eq("midrst_no_write", 64'(n_writes), 64'(wc));

    // Normal frame after reset; mic-only frame shows build-dependent passthrough
    send_frame(500, 500, 0, 0, 0, 0, 0, 1, 1);
    wait_write();

    repeat (3) @(negedge CLOCK_50);
    check_eq("sb_drained", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
